ofs_plat_ccip_fiu_responder: RTL and testbench

- FIU-side CCI-P endpoint model: accepts AFU c0 read-line and c1 write-line requests and answers them from a small internal line memory.
- Adds configurable latency, response-rate throttling and almost-full back-pressure.
- Sits where the host FIU would, so AFU shims and tests can close a CCI-P loop without a platform.
- Single-line requests only (cl_len = 0); c0 and c1 are handled independently.

---
 rtl/ofs_plat_ccip_fiu_responder.sv | 219 +++++++++++++++++++++
 tb/tb_ofs_plat_ccip_fiu_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_plat_ccip_fiu_responder.sv
// FIU-side CCI-P responder: answers c0 line reads and c1 line writes from a small internal line memory.
// Latency: a response issues no earlier than LATENCY cycles after acceptance, at most one per RSP_GAP+1 cycles per channel.
// Backpressure: none on requests; almfull is advisory and a push to a full queue is dropped and flagged sticky.

// Per-channel response queue: holds {payload, timestamp}, releases the head once it is old enough and the gap has elapsed.
module ofs_plat_ccip_fiu_rsp_queue #(
  parameter int W        = 16,
  parameter int DEPTH    = 16,
  parameter int AF_SLACK = 4,
  parameter int LATENCY  = 8,
  parameter int RSP_GAP  = 0,
  parameter int TS_W     = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push_vld,
  input  logic [W-1:0]    push_dat,
  input  logic [TS_W-1:0] ts_now,
  output logic            rsp_vld,
  output logic [W-1:0]    rsp_dat,
  output logic            almfull,
  output logic            ovf_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (RSP_GAP > 0) ? $clog2(RSP_GAP + 1) : 1;

  logic [W-1:0]    pay_q [DEPTH];
  logic [TS_W-1:0] ets_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic [W-1:0]     rsp_dat_q, rsp_dat_d;
  logic             almfull_q, almfull_d;
  logic             ovf_q, ovf_d;

  logic [TS_W-1:0] age;
  logic            issue;
  logic            push_ok;

  // Issue decision, push admission and next-state for pointers, throttle and status outputs.
  always_comb begin
    // Modular subtraction makes the age correct across timestamp wrap.
    age     = ts_now - ets_q[rd_ptr_q];
    issue   = (cnt_q != '0) && (age >= TS_W'(LATENCY)) && (gap_q == '0);
    // A full queue still takes a push when the head leaves in the same cycle.
    push_ok = push_vld && ((cnt_q != CNT_W'(DEPTH)) || issue);

    wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d  = rd_ptr_q + PTR_W'(issue);
    cnt_d     = cnt_q + CNT_W'(push_ok) - CNT_W'(issue);

    gap_d = gap_q;
    if (issue) begin
      gap_d = GAP_W'(RSP_GAP);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end

    rsp_vld_d = issue;
    rsp_dat_d = issue ? pay_q[rd_ptr_q] : '0;
    almfull_d = (cnt_d >= CNT_W'(DEPTH - AF_SLACK));
    ovf_d     = ovf_q | (push_vld & ~push_ok);
  end

  // Queue storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pay_q[wr_ptr_q] <= push_dat;
      ets_q[wr_ptr_q] <= ts_now;
    end
  end

  // Control and registered outputs, cleared asynchronously so nothing queued survives reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
      almfull_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
      almfull_q <= almfull_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rsp_vld = rsp_vld_q;
  assign rsp_dat = rsp_dat_q;
  assign almfull = almfull_q;
  assign ovf_err = ovf_q;
endmodule

// Top level: line memory, free-running timestamp and one response queue per channel.
module ofs_plat_ccip_fiu_responder #(
  parameter int ADDR_W    = 42,
  parameter int MEM_IDX_W = 6,
  parameter int LATENCY   = 8,
  parameter int RSP_GAP   = 0,
  parameter int DEPTH     = 16,
  parameter int AF_SLACK  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c0_req_valid,
  input  logic [ADDR_W-1:0] c0_req_addr,
  input  logic [15:0]       c0_req_mdata,
  input  logic              c1_req_valid,
  input  logic [ADDR_W-1:0] c1_req_addr,
  input  logic [15:0]       c1_req_mdata,
  input  logic [511:0]      c1_req_data,
  output logic              c0_almfull,
  output logic              c1_almfull,
  output logic              c0_rsp_valid,
  output logic [15:0]       c0_rsp_mdata,
  output logic [511:0]      c0_rsp_data,
  output logic              c1_rsp_valid,
  output logic [15:0]       c1_rsp_mdata,
  output logic [1:0]        overflow_err
);
  localparam int TS_W   = 15;
  localparam int LINES  = 2 ** MEM_IDX_W;
  localparam int C0_W   = 16 + 512;

  logic [511:0] mem [LINES];

  logic [TS_W-1:0] ts_q, ts_d;

  logic [MEM_IDX_W-1:0] c0_idx;
  logic [MEM_IDX_W-1:0] c1_idx;
  logic [511:0]         c0_rd_data;
  logic [C0_W-1:0]      c0_rsp_dat;
  logic                 c0_ovf;
  logic                 c1_ovf;

  // Only the low address bits select a line; the rest are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c0_req_addr[ADDR_W-1:MEM_IDX_W], c1_req_addr[ADDR_W-1:MEM_IDX_W]};

  assign c0_idx     = c0_req_addr[MEM_IDX_W-1:0];
  assign c1_idx     = c1_req_addr[MEM_IDX_W-1:0];
  // Sampled at the acceptance edge, so a same-cycle write to this line is not yet visible.
  assign c0_rd_data = mem[c0_idx];

  // Timestamp advances every cycle and wraps freely.
  always_comb begin
    ts_d = ts_q + TS_W'(1);
  end

  // Timestamp register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  // Line memory write; also performed when the c1 queue drops the ack.
  always_ff @(posedge clk) begin
    if (reset_n && c1_req_valid) begin
      mem[c1_idx] <= c1_req_data;
    end
  end

  ofs_plat_ccip_fiu_rsp_queue #(
    .W        (C0_W),
    .DEPTH    (DEPTH),
    .AF_SLACK (AF_SLACK),
    .LATENCY  (LATENCY),
    .RSP_GAP  (RSP_GAP),
    .TS_W     (TS_W)
  ) u_c0_q (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (c0_req_valid),
    .push_dat ({c0_req_mdata, c0_rd_data}),
    .ts_now   (ts_q),
    .rsp_vld  (c0_rsp_valid),
    .rsp_dat  (c0_rsp_dat),
    .almfull  (c0_almfull),
    .ovf_err  (c0_ovf)
  );

  ofs_plat_ccip_fiu_rsp_queue #(
    .W        (16),
    .DEPTH    (DEPTH),
    .AF_SLACK (AF_SLACK),
    .LATENCY  (LATENCY),
    .RSP_GAP  (RSP_GAP),
    .TS_W     (TS_W)
  ) u_c1_q (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (c1_req_valid),
    .push_dat (c1_req_mdata),
    .ts_now   (ts_q),
    .rsp_vld  (c1_rsp_valid),
    .rsp_dat  (c1_rsp_mdata),
    .almfull  (c1_almfull),
    .ovf_err  (c1_ovf)
  );

  assign c0_rsp_mdata = c0_rsp_dat[C0_W-1:512];
  assign c0_rsp_data  = c0_rsp_dat[511:0];
  assign overflow_err = {c1_ovf, c0_ovf};
endmodule

// File: tb/tb_ofs_plat_ccip_fiu_responder.sv
// Randomized and directed stimulus for the CCI-P FIU responder.
// Every cycle's outputs are compared against a queue-based transaction model.
// Expected responses come from acceptance cycle numbers, not from timestamps.
module tb_ofs_plat_ccip_fiu_responder;
  localparam int ADDR_W    = 42;
  localparam int MEM_IDX_W = 6;
  localparam int LATENCY   = 8;
  localparam int RSP_GAP   = 2;
  localparam int DEPTH     = 16;
  localparam int AF_SLACK  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              c0_req_valid = 1'b0;
  logic [ADDR_W-1:0] c0_req_addr = '0;
  logic [15:0]       c0_req_mdata = '0;
  logic              c1_req_valid = 1'b0;
  logic [ADDR_W-1:0] c1_req_addr = '0;
  logic [15:0]       c1_req_mdata = '0;
  logic [511:0]      c1_req_data = '0;
  logic              c0_almfull, c1_almfull;
  logic              c0_rsp_valid, c1_rsp_valid;
  logic [15:0]       c0_rsp_mdata, c1_rsp_mdata;
  logic [511:0]      c0_rsp_data;
  logic [1:0]        overflow_err;

  always #5 clk = ~clk;

  ofs_plat_ccip_fiu_responder #(
    .ADDR_W(ADDR_W), .MEM_IDX_W(MEM_IDX_W), .LATENCY(LATENCY),
    .RSP_GAP(RSP_GAP), .DEPTH(DEPTH), .AF_SLACK(AF_SLACK)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_mdata(c1_req_mdata),
    .c1_req_data(c1_req_data),
    .c0_almfull(c0_almfull), .c1_almfull(c1_almfull),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
    .overflow_err(overflow_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction model: each queued entry remembers the cycle it was accepted in.
  typedef struct {
    logic [15:0]  mdata;
    logic [511:0] data;
    int           acc;
  } ent_t;

  ent_t         q0[$];
  ent_t         q1[$];
  logic [511:0] mem_m [2**MEM_IDX_W];
  int           cyc  = 0;
  int           nxt0 = 0;
  int           nxt1 = 0;
  bit           ovf0 = 0;
  bit           ovf1 = 0;
  bit           e0v, e1v;
  logic [15:0]  e0m, e1m;
  logic [511:0] e0d;
  int           acc0 = 0;
  int           dut_c0_rsp = 0;

  task automatic model_step();
    ent_t e;
    int   i0, i1;
    cyc++;
    i0  = int'(c0_req_addr[MEM_IDX_W-1:0]);
    i1  = int'(c1_req_addr[MEM_IDX_W-1:0]);
    e0v = 0;
    e1v = 0;
    if (q0.size() > 0 && cyc - q0[0].acc >= LATENCY && cyc >= nxt0) begin
      e = q0.pop_front();
      e0v = 1; e0m = e.mdata; e0d = e.data;
      nxt0 = cyc + RSP_GAP + 1;
    end
    if (q1.size() > 0 && cyc - q1[0].acc >= LATENCY && cyc >= nxt1) begin
      e = q1.pop_front();
      e1v = 1; e1m = e.mdata;
      nxt1 = cyc + RSP_GAP + 1;
    end
    if (c0_req_valid) begin
      if (q0.size() < DEPTH) begin
        e.mdata = c0_req_mdata; e.data = mem_m[i0]; e.acc = cyc;
        q0.push_back(e);
        acc0++;
      end else begin
        ovf0 = 1;
      end
    end
    if (c1_req_valid) begin
      if (q1.size() < DEPTH) begin
        e.mdata = c1_req_mdata; e.data = '0; e.acc = cyc;
        q1.push_back(e);
      end else begin
        ovf1 = 1;
      end
      mem_m[i1] = c1_req_data;
    end
  endtask

  task automatic tick(input bit v0, input logic [ADDR_W-1:0] a0, input logic [15:0] m0,
                      input bit v1, input logic [ADDR_W-1:0] a1, input logic [15:0] m1,
                      input logic [511:0] d1);
    @(negedge clk);
    c0_req_valid = v0; c0_req_addr = a0; c0_req_mdata = m0;
    c1_req_valid = v1; c1_req_addr = a1; c1_req_mdata = m1; c1_req_data = d1;
    @(posedge clk);
    model_step();
    #1;
    if (c0_rsp_valid) dut_c0_rsp++;
    check("c0_rsp_valid", c0_rsp_valid, e0v);
    if (e0v) begin
      check("c0_rsp_mdata", c0_rsp_mdata, e0m);
      check("c0_rsp_data", c0_rsp_data, e0d);
    end
    check("c1_rsp_valid", c1_rsp_valid, e1v);
    if (e1v) check("c1_rsp_mdata", c1_rsp_mdata, e1m);
    check("c0_almfull", c0_almfull, q0.size() >= DEPTH - AF_SLACK);
    check("c1_almfull", c1_almfull, q1.size() >= DEPTH - AF_SLACK);
    check("overflow_err", overflow_err, {ovf1, ovf0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, '0, '0, 0, '0, '0, '0);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[ADDR_W-1:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_c0_rsp_valid"}, c0_rsp_valid, 0);
    check({tag, "_c1_rsp_valid"}, c1_rsp_valid, 0);
    check({tag, "_c0_rsp_data"}, c0_rsp_data, 0);
    check({tag, "_c0_rsp_mdata"}, c0_rsp_mdata, 0);
    check({tag, "_c1_rsp_mdata"}, c1_rsp_mdata, 0);
    check({tag, "_almfull"}, {c1_almfull, c0_almfull}, 0);
    check({tag, "_overflow_err"}, overflow_err, 0);
  endtask

  initial begin
    logic [511:0] pat;
    int           dut_before, acc_before;

    // Reset state.
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Give every line a known value, spaced so the c1 queue never fills.
    for (int i = 0; i < 2**MEM_IDX_W; i++) begin
      tick(0, '0, '0, 1, ADDR_W'(i), 16'(i), rand512());
      idle(2);
    end
    idle(20);

    // Write then read the same line.
    pat = {16{32'hA5A5_A5A5}};
    tick(0, '0, '0, 1, ADDR_W'(5), 16'h0011, pat);
    tick(1, ADDR_W'(5), 16'h0022, 0, '0, '0, '0);
    idle(12);

    // Same-cycle read and write to one line, then a read in the next cycle.
    tick(1, ADDR_W'(3), 16'h0030, 1, ADDR_W'(3), 16'h0031, rand512());
    tick(1, ADDR_W'(3), 16'h0032, 0, '0, '0, '0);
    idle(15);

    // Five back-to-back reads, throttled by the response gap.
    for (int i = 0; i < 5; i++) tick(1, rand_addr(), 16'h0100 + 16'(i), 0, '0, '0, '0);
    idle(30);

    // Random mixed traffic.
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 99) < 30, rand_addr(), 16'($urandom()),
           $urandom_range(0, 99) < 30, rand_addr(), 16'($urandom()), rand512());
    end
    idle(80);

    // Burst long enough to overflow the c0 queue; writes keep landing on c1 too.
    dut_before = dut_c0_rsp;
    acc_before = acc0;
    for (int i = 0; i < 40; i++) begin
      tick(1, rand_addr(), 16'h0200 + 16'(i), (i % 2) == 0, rand_addr(), 16'h0300 + 16'(i), rand512());
    end
    check("burst_overflow_c0", overflow_err[0], 1'b1);
    idle(DEPTH * (RSP_GAP + 1) + LATENCY + 10);
    check("burst_rsp_count", 32'(dut_c0_rsp - dut_before), 32'(acc0 - acc_before));

    // Align the acceptance timestamp just below the wrap point.
    for (int i = 0; i < 32768 && (cyc % 32768) != 32762; i++) idle(1);
    tick(1, rand_addr(), 16'h0400, 1, rand_addr(), 16'h0401, rand512());
    tick(1, rand_addr(), 16'h0402, 0, '0, '0, '0);
    idle(20);

    // Reset asserted between edges while a response is on the outputs.
    for (int i = 0; i < 4; i++) tick(1, rand_addr(), 16'h0500 + 16'(i), 1, rand_addr(), 16'h0600 + 16'(i), rand512());
    idle(5);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    q0.delete(); q1.delete();
    nxt0 = 0; nxt1 = 0; ovf0 = 0; ovf1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
